// File: rtl/adc_fe_pkg.sv
// Shared widths, the per-channel conversion mode and the linear-mode zero sentinel.
// Pure declarations: no timing, no flow control.
package adc_fe_pkg;

    localparam int RAW_W_DEF        = 14;
    localparam int DEC_MAX_LOG2_DEF = 4;
    localparam int ACC_W_DEF        = RAW_W_DEF + DEC_MAX_LOG2_DEF;
    localparam int SENT_W           = 32;

    typedef enum logic [1:0] {
        TWOS     = 2'b00,
        TWOS_INV = 2'b01,
        LIN      = 2'b10,
        LIN_INV  = 2'b11
    } conv_mode_t;

    function automatic conv_mode_t mode_of(input logic lin, input logic inv);
        return conv_mode_t'({lin, inv});
    endfunction

    // Linear format reserves 0, so a zero result is pushed up to the smallest legal code.
    function automatic logic [SENT_W-1:0] sat_sentinel(input logic [SENT_W-1:0] v, input logic lin);
        if (lin && (v == '0)) begin
            return SENT_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/adc_fe_chan.sv
// One ADC channel: registered format conversion, boxcar accumulator, average and sentinel.
// Latency 1 clock for conversion plus 1 for the output register; no backpressure.
module adc_fe_chan
    import adc_fe_pkg::*;
#(
    parameter int RAW_W = RAW_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int DEC_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RAW_W-1:0] raw_i,
    input  conv_mode_t       mode_i,
    input  logic [DEC_W-1:0] dec_i,
    input  logic             acc_en_i,
    input  logic             fin_i,
    input  logic             clr_i,
    output logic [RAW_W-1:0] dat_o
);

    localparam int EXT_W = ACC_W - RAW_W;

    logic [RAW_W-1:0]        conv_d, conv_q;
    logic [ACC_W-1:0]        acc_q;
    logic [RAW_W-1:0]        dat_d, dat_q;
    logic                    lin;
    logic                    ext_bit;
    logic [ACC_W-1:0]        ext_d, sum_d, sh_u, sh_s, avg_d;
    logic [SENT_W-1:0]       sent_in, sent_out;
    logic [EXT_W-1:0]        unused_avg_hi;
    logic [SENT_W-RAW_W-1:0] unused_sent_hi;

    assign lin = (mode_i == LIN) || (mode_i == LIN_INV);

    always_comb begin
        conv_d = raw_i;
        case (mode_i)
            TWOS:     conv_d = {~raw_i[RAW_W-1], raw_i[RAW_W-2:0]};
            TWOS_INV: conv_d = {raw_i[RAW_W-1], ~raw_i[RAW_W-2:0]};
            LIN:      conv_d = raw_i;
            LIN_INV:  conv_d = ~raw_i;
            default:  conv_d = raw_i;
        endcase
    end

    // Two's-complement samples sign-extend into the accumulator, linear ones zero-extend.
    always_comb begin
        ext_bit  = lin ? 1'b0 : conv_q[RAW_W-1];
        ext_d    = {{EXT_W{ext_bit}}, conv_q};
        sum_d    = acc_q + ext_d;
        sh_u     = sum_d >> dec_i;
        sh_s     = ACC_W'($signed(sum_d) >>> dec_i);
        avg_d    = lin ? sh_u : sh_s;
        sent_in  = SENT_W'(avg_d[RAW_W-1:0]);
        sent_out = sat_sentinel(sent_in, lin);
        dat_d    = sent_out[RAW_W-1:0];
    end

    assign unused_avg_hi  = avg_d[ACC_W-1:RAW_W];
    assign unused_sent_hi = sent_out[SENT_W-1:RAW_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conv_q <= '0;
            acc_q  <= '0;
            dat_q  <= '0;
        end else begin
            conv_q <= conv_d;
            if (clr_i || fin_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= sum_d;
            end
            if (fin_i) begin
                dat_q <= dat_d;
            end
        end
    end

    assign dat_o = dat_q;

endmodule

// File: rtl/red_pitaya_adc_frontend.sv
// Multi-channel ADC front end: shadow config, shared decimation window, valid strobe, over-range.
// Latency 2 clocks at dec=0; no backpressure. Over-range detection built only with ADC_FE_OVR_EN.
module red_pitaya_adc_frontend
    import adc_fe_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int RAW_W        = RAW_W_DEF,
    parameter int DEC_MAX_LOG2 = DEC_MAX_LOG2_DEF
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rst_i,
    input  logic [NCH*RAW_W-1:0] adc_raw_i,
    input  logic [NCH-1:0]       ch_invert_i,
    input  logic [NCH-1:0]       ch_linear_i,
    input  logic [3:0]           dec_log2_i,
    input  logic                 cfg_load_i,
    output logic [NCH*RAW_W-1:0] dat_o,
    output logic                 dat_valid_o,
    output logic [NCH-1:0]       ovr_o,
    input  logic                 ovr_clr_i
);

    localparam int ACC_W = RAW_W + DEC_MAX_LOG2;
    localparam int DEC_W = $clog2(DEC_MAX_LOG2 + 1);
    localparam int CNT_W = DEC_MAX_LOG2;

    logic [NCH-1:0]   inv_d, inv_q;
    logic [NCH-1:0]   lin_d, lin_q;
    logic [DEC_W-1:0] dec_d, dec_q, dec_new;
    logic [CNT_W-1:0] cnt_d, cnt_q, last_cnt;
    logic             s1_vld_d, s1_vld_q;
    logic             vld_d, vld_q;
    logic             win_last, acc_en, fin;

    assign dec_new  = (dec_log2_i > 4'(DEC_MAX_LOG2)) ? DEC_W'(DEC_MAX_LOG2) : dec_log2_i[DEC_W-1:0];
    assign last_cnt = CNT_W'((1 << dec_q) - 1);
    assign win_last = (cnt_q == last_cnt);

    // A config load flushes the pipe: the sample converted this cycle used the old config.
    assign acc_en = s1_vld_q & ~win_last & ~cfg_load_i;
    assign fin    = s1_vld_q &  win_last & ~cfg_load_i;

    always_comb begin
        inv_d    = inv_q;
        lin_d    = lin_q;
        dec_d    = dec_q;
        cnt_d    = cnt_q;
        s1_vld_d = ~cfg_load_i;
        vld_d    = 1'b0;
        if (cfg_load_i) begin
            inv_d = ch_invert_i;
            lin_d = ch_linear_i;
            dec_d = dec_new;
            cnt_d = '0;
        end else if (s1_vld_q) begin
            cnt_d = win_last ? '0 : cnt_q + CNT_W'(1);
            vld_d = win_last;
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            inv_q    <= '0;
            lin_q    <= '0;
            dec_q    <= '0;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            inv_q    <= inv_d;
            lin_q    <= lin_d;
            dec_q    <= dec_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= s1_vld_d;
            vld_q    <= vld_d;
        end
    end

    assign dat_valid_o = vld_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        conv_mode_t mode;
        assign mode = mode_of(lin_q[g], inv_q[g]);

        adc_fe_chan #(
            .RAW_W (RAW_W),
            .ACC_W (ACC_W),
            .DEC_W (DEC_W)
        ) u_chan (
            .clk_i    (adc_clk_i),
            .rst_i    (adc_rst_i),
            .raw_i    (adc_raw_i[g*RAW_W +: RAW_W]),
            .mode_i   (mode),
            .dec_i    (dec_q),
            .acc_en_i (acc_en),
            .fin_i    (fin),
            .clr_i    (cfg_load_i),
            .dat_o    (dat_o[g*RAW_W +: RAW_W])
        );
    end

`ifdef ADC_FE_OVR_EN
    logic [NCH-1:0] ovr_q, ovr_hit;

    always_comb begin
        ovr_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            ovr_hit[c] = (adc_raw_i[c*RAW_W +: RAW_W] == '0) ||
                         (adc_raw_i[c*RAW_W +: RAW_W] == '1);
        end
    end

    // A new hit outranks a clear arriving in the same cycle.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= (ovr_clr_i ? '0 : ovr_q) | ovr_hit;
        end
    end

    assign ovr_o = ovr_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr_i;
    assign ovr_o          = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_adc_frontend.sv
// Directed bench for red_pitaya_adc_frontend (NCH=2, RAW_W=14); expected values hand-computed.
module tb_red_pitaya_adc_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] raw;
    logic [1:0]  inv;
    logic [1:0]  lin;
    logic [3:0]  dec;
    logic        cfg_load;
    logic        ovr_clr;
    logic [27:0] dat;
    logic        vld;
    logic [1:0]  ovr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    red_pitaya_adc_frontend #(
        .NCH          (2),
        .RAW_W        (14),
        .DEC_MAX_LOG2 (4)
    ) dut (
        .adc_clk_i   (clk),
        .adc_rst_i   (rst),
        .adc_raw_i   (raw),
        .ch_invert_i (inv),
        .ch_linear_i (lin),
        .dec_log2_i  (dec),
        .cfg_load_i  (cfg_load),
        .dat_o       (dat),
        .dat_valid_o (vld),
        .ovr_o       (ovr),
        .ovr_clr_i   (ovr_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [1:0] l, input logic [1:0] i, input logic [3:0] d);
        lin      = l;
        inv      = i;
        dec      = d;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        raw = {14'h2000, 14'h2000};
        tick();
        tick();
        tick();
        checks++;
        if (dat !== 28'h0) begin
            errors++;
            $display("FAIL reset_dat: got %h expected %h", dat, 28'h0);
        end
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got %b expected 0", vld);
        end
        checks++;
        if (ovr !== 2'b00) begin
            errors++;
            $display("FAIL reset_ovr: got %b expected 00", ovr);
        end
        rst = 1'b0;
    endtask

    task automatic test_twos_dec0;
        logic [13:0] vin [3] = '{14'h2000, 14'h3FFF, 14'h0000};
        logic [13:0] vexp [3] = '{14'h0000, 14'h1FFF, 14'h2000};
        tick();
        tick();
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) raw = {14'h0001, vin[i]};
            tick();
            if (i >= 1) begin
                checks++;
                if (dat !== {14'h2001, vexp[i-1]}) begin
                    errors++;
                    $display("FAIL twos_dat[%0d]: got %h expected %h", i - 1, dat, {14'h2001, vexp[i-1]});
                end
                checks++;
                if (vld !== 1'b1) begin
                    errors++;
                    $display("FAIL twos_vld[%0d]: got %b expected 1", i - 1, vld);
                end
            end
        end
    endtask

    task automatic test_lin_inv;
        logic [13:0] vin [2] = '{14'h3FFF, 14'h0000};
        logic [13:0] vexp [2] = '{14'h0001, 14'h3FFF};
        load_cfg(2'b11, 2'b11, 4'd0);
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL lin_cfg_vld: got %b expected 0", vld);
        end
        for (int i = 0; i <= 2; i++) begin
            if (i < 2) raw = {14'h1234, vin[i]};
            tick();
            if (i >= 1) begin
                checks++;
                if (dat !== {14'h2DCB, vexp[i-1]} || vld !== 1'b1) begin
                    errors++;
                    $display("FAIL lin_dat[%0d]: got %h/%b expected %h/1", i - 1, dat, vld, {14'h2DCB, vexp[i-1]});
                end
            end
        end
    endtask

    task automatic test_dec2;
        logic [13:0] vin [4] = '{14'h2004, 14'h2008, 14'h200C, 14'h2010};
        int          pulses = 0;
        int          pulse_at = -1;
        logic [27:0] pulse_dat = '0;
        load_cfg(2'b00, 2'b00, 4'd2);
        for (int i = 0; i < 8; i++) begin
            raw = (i < 4) ? {14'h1FFF, vin[i]} : {14'h1FFF, 14'h2000};
            tick();
            if (vld === 1'b1) begin
                pulses++;
                pulse_at  = i;
                pulse_dat = dat;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL dec2_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (pulse_at !== 4) begin
            errors++;
            $display("FAIL dec2_pulse_cycle: got %0d expected 4", pulse_at);
        end
        checks++;
        if (pulse_dat !== {14'h3FFF, 14'h000A}) begin
            errors++;
            $display("FAIL dec2_avg: got %h expected %h", pulse_dat, {14'h3FFF, 14'h000A});
        end
        checks++;
        if (dat !== {14'h3FFF, 14'h000A}) begin
            errors++;
            $display("FAIL dec2_hold: got %h expected %h", dat, {14'h3FFF, 14'h000A});
        end
    endtask

    task automatic test_cfg_on_final;
        int          first = -1;
        logic [27:0] fdat = '0;
        load_cfg(2'b00, 2'b00, 4'd2);
        raw = {14'h1FFF, 14'h2100};
        for (int i = 0; i < 4; i++) tick();
        dec      = 4'd3;
        cfg_load = 1'b1;
        raw      = {14'h1FFF, 14'h2010};
        tick();
        cfg_load = 1'b0;
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL cfgfinal_suppress: got %b expected 0", vld);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (vld === 1'b1 && first < 0) begin
                first = i;
                fdat  = dat;
            end
        end
        checks++;
        if (first !== 9) begin
            errors++;
            $display("FAIL cfgfinal_first_cycle: got %0d expected 9", first);
        end
        checks++;
        if (fdat !== {14'h3FFF, 14'h0010}) begin
            errors++;
            $display("FAIL cfgfinal_avg: got %h expected %h", fdat, {14'h3FFF, 14'h0010});
        end
    endtask

    task automatic test_reset_mid;
        load_cfg(2'b11, 2'b11, 4'd2);
        raw = {14'h1FFF, 14'h2005};
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (dat !== 28'h0 || vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h/%b expected %h/0", dat, vld, 28'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_vld_early: got %b expected 0", vld);
        end
        tick();
        checks++;
        if (vld !== 1'b1) begin
            errors++;
            $display("FAIL midrst_vld: got %b expected 1", vld);
        end
        checks++;
        if (dat !== {14'h3FFF, 14'h0005}) begin
            errors++;
            $display("FAIL midrst_dat: got %h expected %h", dat, {14'h3FFF, 14'h0005});
        end
    endtask

    task automatic test_ovr;
`ifdef ADC_FE_OVR_EN
        ovr_clr = 1'b1;
        raw     = {14'h2000, 14'h2000};
        tick();
        ovr_clr = 1'b0;
        checks++;
        if (ovr !== 2'b00) begin
            errors++;
            $display("FAIL ovr_initial_clear: got %b expected 00", ovr);
        end
        raw = {14'h3FFF, 14'h2000};
        tick();
        checks++;
        if (ovr !== 2'b10) begin
            errors++;
            $display("FAIL ovr_set: got %b expected 10", ovr);
        end
        ovr_clr = 1'b1;
        tick();
        checks++;
        if (ovr !== 2'b10) begin
            errors++;
            $display("FAIL ovr_set_beats_clr: got %b expected 10", ovr);
        end
        raw = {14'h2000, 14'h2000};
        tick();
        ovr_clr = 1'b0;
        checks++;
        if (ovr !== 2'b00) begin
            errors++;
            $display("FAIL ovr_clr: got %b expected 00", ovr);
        end
`else
        raw = {14'h3FFF, 14'h0000};
        tick();
        tick();
        checks++;
        if (ovr !== 2'b00) begin
            errors++;
            $display("FAIL ovr_tied_off: got %b expected 00", ovr);
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        raw      = '0;
        inv      = '0;
        lin      = '0;
        dec      = '0;
        cfg_load = 1'b0;
        ovr_clr  = 1'b0;
        test_reset();
        test_twos_dec0();
        test_lin_inv();
        test_dec2();
        test_cfg_on_final();
        test_reset_mid();
        test_ovr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
